// File: rtl/round_robin_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a bounded hold time.
// A holder keeps its grant while it requests, until MAX_HOLD cycles pass with a rival pending.
module round_robin_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic [2:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;

  logic       idle_found, busy_found;
  logic [2:0] idle_idx, busy_idx;
  logic [2:0] probe;
  logic [7:0] others;
  logic       release_hit, timeout_hit;

  // Pointer-order search starting at last+1; the BUSY search stops short of the holder itself.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = last_q;
    busy_found = 1'b0;
    busy_idx   = last_q;
    probe      = last_q;
    for (int unsigned k = 1; k <= 8; k++) begin
      probe = last_q + 3'(k);
      if (!idle_found && req[probe]) begin
        idle_found = 1'b1;
        idle_idx   = probe;
      end
      if (k < 8 && !busy_found && req[probe]) begin
        busy_found = 1'b1;
        busy_idx   = probe;
      end
    end
  end

  always_comb begin
    others       = req & ~(8'd1 << sel_q);
    release_hit  = !req[sel_q];
    timeout_hit  = (hold_q == HOLD_LIMIT) && (others != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 3'd7;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (en && idle_found) begin
          state_d = BUSY;
          sel_d   = idle_idx;
          last_d  = idle_idx;
          hold_d  = '0;
        end
      end
      BUSY: begin
        if (release_hit || timeout_hit) begin
          if (en && busy_found) begin
            sel_d  = busy_idx;
            last_d = busy_idx;
            hold_d = '0;
          end else if (release_hit) begin
            state_d = IDLE;
            hold_d  = '0;
          end
          // timeout with en low: keep the grant, counter stays saturated
        end else if (hold_q != HOLD_LIMIT) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = (state_d == BUSY);
    grant_d = valid_d ? (8'd1 << sel_d) : '0;
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Directed bench for round_robin_arbiter_8 with MAX_HOLD=4 and hand-computed expectations.
module tb_round_robin_arbiter_8;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;

  int unsigned checks = 0;
  int unsigned errors = 0;

  round_robin_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .grant (grant),
    .sel   (sel),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    step();
  endtask

  initial begin
    logic [7:0] exp_g;

    // reset state and first grants
    reset_dut();
    step();
    check("rst_grant", grant, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_sel",   sel,   3'd0);
    check("rst_last",  dut.last_q, 3'd7);
    check("rst_hold",  dut.hold_q, 8'd0);
    rst_n = 1'b1; req = 8'h81; step();
    check("p81_grant", grant, 8'h01);
    check("p81_sel",   sel,   3'd0);
    check("p81_valid", valid, 1'b1);
    req = 8'h80; step();
    check("p80_grant", grant, 8'h80);
    check("p80_sel",   sel,   3'd7);

    // en gating in IDLE
    reset_dut();
    rst_n = 1'b1; en = 1'b0; req = 8'h0F; step(); step();
    check("en0_grant", grant, 8'h00);
    check("en0_valid", valid, 1'b0);
    en = 1'b1; step();
    check("en1_grant", grant, 8'h01);

    // full rotation with timeout, 4 cycles each, no gap
    reset_dut();
    rst_n = 1'b1; req = 8'hFF; step();
    for (int unsigned g = 0; g < 9; g++) begin
      exp_g = 8'd1 << (g % 8);
      for (int unsigned c = 0; c < MAX_HOLD; c++) begin
        check($sformatf("rot_grant_%0d_%0d", g, c), grant, exp_g);
        check($sformatf("rot_valid_%0d_%0d", g, c), valid, 1'b1);
        step();
      end
    end

    // single requester holds indefinitely, counter saturates
    reset_dut();
    rst_n = 1'b1; req = 8'h10; step();
    for (int unsigned c = 0; c < 50; c++) begin
      check($sformatf("solo_grant_%0d", c), grant, 8'h10);
      step();
    end
    check("solo_hold", dut.hold_q, MAX_HOLD - 1);

    // release hands over with no gap
    reset_dut();
    rst_n = 1'b1; req = 8'h04; step();
    check("rel_first", grant, 8'h04);
    req = 8'h24; step();
    check("rel_hold", grant, 8'h04);
    req = 8'h20; step();
    check("rel_next_grant", grant, 8'h20);
    check("rel_next_sel",   sel,   3'd5);
    check("rel_next_last",  dut.last_q, 3'd5);

    // release with nobody pending goes idle, sel kept
    reset_dut();
    rst_n = 1'b1; req = 8'h04; step();
    req = 8'h00; step();
    check("idle_grant", grant, 8'h00);
    check("idle_valid", valid, 1'b0);
    check("idle_sel",   sel,   3'd2);

    // reset during BUSY revokes at that edge; search restarts at 0
    reset_dut();
    rst_n = 1'b1; req = 8'h20; step();
    check("b5_sel", sel, 3'd5);
    rst_n = 1'b0; step();
    check("rstb_grant", grant, 8'h00);
    check("rstb_valid", valid, 1'b0);
    check("rstb_sel",   sel,   3'd0);
    rst_n = 1'b1; req = 8'h21; step();
    check("rstb_next", grant, 8'h01);

    // timeout with en low keeps grant; en high then hands over
    reset_dut();
    rst_n = 1'b1; req = 8'h03; step();
    en = 1'b0;
    for (int unsigned c = 0; c < 6; c++) step();
    check("to_en0_grant", grant, 8'h01);
    check("to_en0_hold",  dut.hold_q, MAX_HOLD - 1);
    en = 1'b1; step();
    check("to_en1_grant", grant, 8'h02);
    check("to_en1_hold",  dut.hold_q, 8'd0);

    // release with en low goes idle even with a rival pending
    en = 1'b0; req = 8'h01; step();
    check("rel_en0_grant", grant, 8'h00);
    check("rel_en0_valid", valid, 1'b0);

    // holder that drops and re-raises is served after the rest
    reset_dut();
    rst_n = 1'b1; req = 8'h01; step();
    req = 8'h0C; step();
    check("rr_a", grant, 8'h04);
    req = 8'h09; step();
    check("rr_b", grant, 8'h08);
    req = 8'h01; step();
    check("rr_c", grant, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
